// File: rtl/lt_pkg.sv
// Shared types and helpers for the inverse uniform-breakpoint
// piecewise-linear transformation.
package lt_pkg;

  localparam int NSEG = 16;
  localparam int DSIZE_DEF = 12;

  typedef logic [DSIZE_DEF-1:0] lt_table_t [NSEG];

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    SEARCH,
    DIV,
    ROUND,
    OUT
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/lt_serial_div.sv
// Serial restoring divider: one quotient bit per cycle, MSB first.
// Caller guarantees the numerator high part is below the divisor.
module lt_serial_div
  import lt_pkg::*;
#(
  parameter int DW = 12,
  parameter int QW = 5
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DW+QW-1:0] n,
  input  logic [DW-1:0]    d,
  output logic             busy,
  output logic             done,
  output logic [QW-1:0]    q
);

  localparam int CW = clog2(QW) + 1;

  logic [DW-1:0] rem;
  logic [DW-1:0] dr;
  logic [QW-1:0] nlo;
  logic [CW-1:0] cnt;
  logic [DW:0]   trial;
  logic          ge;

  assign trial = {rem, nlo[QW-1]};
  assign ge    = trial >= {1'b0, dr};
  assign done  = busy && (cnt == CW'(QW - 1));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dr   <= '0;
      nlo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      q    <= '0;
    end else if (start) begin
      rem  <= n[DW+QW-1:QW];
      nlo  <= n[QW-1:0];
      dr   <= d;
      cnt  <= '0;
      busy <= 1'b1;
      q    <= '0;
    end else if (busy) begin
      rem <= ge ? DW'(trial - {1'b0, dr})
                : DW'(trial);
      nlo <= nlo << 1;
      q   <= (q << 1) | QW'(ge);
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/linear_transfomation_inv.sv
// Inverse uniform-breakpoint PWL transform: table check, segment
// search, serial divide and round behind valid/ready handshakes.
module linear_transfomation_inv
  import lt_pkg::*;
#(
  parameter int DSIZE = 12,
  parameter int DM    = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             cal_begin,
  output logic             cal_valid,
  output logic             cal_error,
  input  logic [DSIZE-1:0] C00,
  input  logic [DSIZE-1:0] C01,
  input  logic [DSIZE-1:0] C02,
  input  logic [DSIZE-1:0] C03,
  input  logic [DSIZE-1:0] C04,
  input  logic [DSIZE-1:0] C05,
  input  logic [DSIZE-1:0] C06,
  input  logic [DSIZE-1:0] C07,
  input  logic [DSIZE-1:0] C08,
  input  logic [DSIZE-1:0] C09,
  input  logic [DSIZE-1:0] C10,
  input  logic [DSIZE-1:0] C11,
  input  logic [DSIZE-1:0] C12,
  input  logic [DSIZE-1:0] C13,
  input  logic [DSIZE-1:0] C14,
  input  logic [DSIZE-1:0] C15,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data
);

  localparam int LOG2DM = clog2(DM);
  localparam int QW     = LOG2DM + 1;

  state_t state, state_nxt;

  logic [DSIZE-1:0] cin [NSEG];
  logic [DSIZE-1:0] tbl [NSEG];
  logic [3:0]       cal_cnt;
  logic             cal_ok;
  logic             pair_ok;
  logic [DSIZE-1:0] din_q;
  logic [3:0]       seg_k;
  logic [3:0]       k_q;
  logic             lo_sat;
  logic             hi_sat;
  logic [DSIZE-1:0] c_lo;
  logic [DSIZE-1:0] c_hi;
  logic             in_fire;
  logic             out_fire;

  logic [DSIZE+QW-1:0] div_n;
  logic [DSIZE-1:0]    div_d;
  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic [QW-1:0]       div_q;
  logic [QW-1:0]       q_rnd;

  assign cin[0]  = C00;
  assign cin[1]  = C01;
  assign cin[2]  = C02;
  assign cin[3]  = C03;
  assign cin[4]  = C04;
  assign cin[5]  = C05;
  assign cin[6]  = C06;
  assign cin[7]  = C07;
  assign cin[8]  = C08;
  assign cin[9]  = C09;
  assign cin[10] = C10;
  assign cin[11] = C11;
  assign cin[12] = C12;
  assign cin[13] = C13;
  assign cin[14] = C14;
  assign cin[15] = C15;

  assign in_ready = (state == IDLE) && cal_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign pair_ok  = tbl[cal_cnt] < tbl[cal_cnt + 4'd1];

  // Interior segment index: breakpoints at or below the sample.
  always_comb begin
    seg_k = '0;
    for (int i = 1; i < NSEG - 1; i++) begin
      if (tbl[i] <= din_q) seg_k = seg_k + 4'd1;
    end
  end

  assign lo_sat = din_q < tbl[0];
  assign hi_sat = din_q >= tbl[NSEG-1];
  assign c_lo   = tbl[seg_k];
  assign c_hi   = tbl[seg_k + 4'd1];
  assign div_n  = {din_q - c_lo, QW'(0)};
  assign div_d  = c_hi - c_lo;

  assign div_start = (state == SEARCH) && !cal_begin
                  && !lo_sat && !hi_sat && !div_busy;

  // Round half up: q2 is twice the fractional position.
  assign q_rnd = {1'b0, div_q[QW-1:1]} + QW'(div_q[0]);

  lt_serial_div #(
    .DW(DSIZE),
    .QW(QW)
  ) u_div (
    .clock(clock),
    .rst_n(rst_n),
    .start(div_start),
    .n    (div_n),
    .d    (div_d),
    .busy (div_busy),
    .done (div_done),
    .q    (div_q)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cal_begin) begin
      state_nxt = CAL;
    end else begin
      unique case (state)
        IDLE:   if (in_fire) state_nxt = SEARCH;
        CAL:    if (cal_cnt == 4'(NSEG - 2))
                  state_nxt = IDLE;
        SEARCH: state_nxt = (lo_sat || hi_sat)
                          ? OUT : DIV;
        DIV:    if (div_done) state_nxt = ROUND;
        ROUND:  state_nxt = OUT;
        OUT:    if (out_fire) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) tbl[i] <= '0;
      cal_cnt   <= '0;
      cal_ok    <= 1'b0;
      cal_valid <= 1'b0;
      cal_error <= 1'b0;
      din_q     <= '0;
      k_q       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (cal_begin) begin
      for (int i = 0; i < NSEG; i++) tbl[i] <= cin[i];
      cal_cnt   <= '0;
      cal_ok    <= 1'b1;
      cal_valid <= 1'b0;
      cal_error <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) din_q <= in_data;
        end
        CAL: begin
          cal_ok  <= cal_ok && pair_ok;
          cal_cnt <= cal_cnt + 4'd1;
          if (cal_cnt == 4'(NSEG - 2)) begin
            cal_valid <= cal_ok && pair_ok;
            cal_error <= !(cal_ok && pair_ok);
          end
        end
        SEARCH: begin
          k_q <= seg_k;
          if (lo_sat)
            out_data <= '0;
          else if (hi_sat)
            out_data <= DSIZE'(DM * (NSEG - 1));
        end
        ROUND: begin
          out_data <= (DSIZE'(k_q) << LOG2DM)
                    + DSIZE'(q_rnd);
        end
        OUT: begin
          out_valid <= !out_fire;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_transfomation_inv.sv
// Directed bench for linear_transfomation_inv: vector table plus
// hand-written backpressure, recalibration and reset sequences.
module tb_linear_transfomation_inv;
  import lt_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        cal_begin;
  logic        cal_valid;
  logic        cal_error;
  lt_table_t   c;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int sel;
    int din;
    int exp;
    int lat;
  } vec_t;

  vec_t vecs [14];

  always #5 clock = ~clock;

  linear_transfomation_inv #(
    .DSIZE(12),
    .DM(16)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .cal_begin(cal_begin),
    .cal_valid(cal_valid),
    .cal_error(cal_error),
    .C00(c[0]),  .C01(c[1]),  .C02(c[2]),  .C03(c[3]),
    .C04(c[4]),  .C05(c[5]),  .C06(c[6]),  .C07(c[7]),
    .C08(c[8]),  .C09(c[9]),  .C10(c[10]), .C11(c[11]),
    .C12(c[12]), .C13(c[13]), .C14(c[14]), .C15(c[15]),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // 0: C(k)=32k, 1: same with C00=10 C01=13, 2: C05==C04
  task automatic set_table(input int sel);
    for (int k = 0; k < 16; k++) c[k] = 12'(32 * k);
    if (sel == 1) begin
      c[0] = 12'd10;
      c[1] = 12'd13;
    end
    if (sel == 2) c[5] = c[4];
  endtask

  task automatic calibrate(input int sel, input int ok);
    int n;
    set_table(sel);
    @(negedge clock);
    cal_begin = 1'b1;
    @(posedge clock);
    #1 cal_begin = 1'b0;
    n = 0;
    do begin
      @(posedge clock);
      #1 n++;
    end while (!cal_valid && !cal_error && n < 40);
    chk("cal_latency", n, 15);
    chk("cal_valid", int'(cal_valid), ok);
    chk("cal_error", int'(cal_error), 1 - ok);
  endtask

  task automatic accept(input int din);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_wait", int'(n < 100), 1);
    in_valid = 1'b1;
    in_data  = 12'(din);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1 n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic send(input int din, input int exp,
                      input int lat);
    int n;
    accept(din);
    wait_out(n);
    chk($sformatf("lat_in%0d", din), n, lat);
    chk($sformatf("data_in%0d", din),
        int'(out_data), exp);
    @(posedge clock);
    #1 chk("out_valid_drop", int'(out_valid), 0);
  endtask

  initial begin
    int cur_sel;
    int n;
    int seen;

    vecs[0]  = '{0, 100,  50, 8};
    vecs[1]  = '{0,  64,  32, 8};
    vecs[2]  = '{0, 500, 240, 2};
    vecs[3]  = '{0, 480, 240, 2};
    vecs[4]  = '{0, 4095, 240, 2};
    vecs[5]  = '{0,   0,   0, 8};
    vecs[6]  = '{0,  31,  16, 8};
    vecs[7]  = '{0, 479, 240, 8};
    vecs[8]  = '{1,   5,   0, 2};
    vecs[9]  = '{1,   9,   0, 2};
    vecs[10] = '{1,  10,   0, 8};
    vecs[11] = '{1,  11,   5, 8};
    vecs[12] = '{1,  12,  11, 8};
    vecs[13] = '{1,  13,  16, 8};

    rst_n     = 1'b0;
    cal_begin = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    set_table(0);
    #1;
    chk("rst_cal_valid", int'(cal_valid), 0);
    chk("rst_cal_error", int'(cal_error), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;

    cur_sel = -1;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].sel != cur_sel) begin
        cur_sel = vecs[i].sel;
        calibrate(cur_sel, 1);
      end
      send(vecs[i].din, vecs[i].exp, vecs[i].lat);
    end

    // Non-monotonic table blocks the input side.
    calibrate(2, 0);
    chk("bad_in_ready", int'(in_ready), 0);
    seen = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 12'd100;
    repeat (10) begin
      @(posedge clock);
      #1 if (in_ready || out_valid) seen++;
    end
    in_valid = 1'b0;
    chk("bad_ignored", seen, 0);

    // Backpressure: result held until out_ready.
    calibrate(0, 1);
    out_ready = 1'b0;
    accept(100);
    wait_out(n);
    chk("hold_lat", n, 8);
    seen = 0;
    repeat (5) begin
      @(posedge clock);
      #1 if (out_data != 12'd50 || in_ready
             || !out_valid) seen++;
    end
    chk("hold_stable", seen, 0);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("hold_ov_drop", int'(out_valid), 0);
    chk("hold_in_ready", int'(in_ready), 1);

    // Recalibration while dividing drops the sample.
    accept(100);
    repeat (3) @(posedge clock);
    @(negedge clock);
    cal_begin = 1'b1;
    @(posedge clock);
    #1 cal_begin = 1'b0;
    chk("recal_cv_clear", int'(cal_valid), 0);
    seen = 0;
    n = 0;
    do begin
      @(posedge clock);
      #1 n++;
      if (out_valid) seen++;
    end while (!cal_valid && !cal_error && n < 40);
    chk("recal_no_out", seen, 0);
    chk("recal_latency", n, 15);
    chk("recal_valid", int'(cal_valid), 1);
    send(64, 32, 8);

    // Asynchronous reset in the middle of a divide.
    send(100, 50, 8);
    accept(100);
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cal_valid", int'(cal_valid), 0);
    chk("mid_rst_cal_error", int'(cal_error), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_rst_cal_valid", int'(cal_valid), 0);
    chk("post_rst_in_ready", int'(in_ready), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
